cache_fill_fsm: RTL and testbench

//   Miss-handling controller between the I-/D-cache arrays and the multi-cycle pipelined main memory.
//   On a cache miss it fetches the whole 16-byte block: 8 word requests on consecutive cycles, each

---
 rtl/cache_fill_fsm.sv | 124 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: on a miss it streams one block's word requests to pipelined main
// memory, writes each returned word into the data array, then writes the tag and pulses fill_done.
module cache_fill_fsm #(
    parameter int WORDS    = 8,
    parameter int OFFSET_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                miss_detected,
    input  logic [15:0]         miss_address,
    input  logic                memory_data_valid,
    input  logic [15:0]         memory_data,
    output logic                fsm_busy,
    output logic                mem_req,
    output logic [15:0]         memory_address,
    output logic                write_data_array,
    output logic                write_tag_array,
    output logic [OFFSET_W-1:0] word_offset,
    output logic [15:0]         fill_data,
    output logic                fill_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counters carry one extra bit so the request counter can rest at WORDS.
    localparam logic [OFFSET_W:0] CNT_FULL   = (OFFSET_W+1)'(WORDS);
    localparam logic [OFFSET_W:0] CNT_LAST   = (OFFSET_W+1)'(WORDS - 1);
    localparam logic [15:0]       BLOCK_MASK = ~16'(2 * WORDS - 1);

    state_t            state_q, state_d;
    logic [OFFSET_W:0] req_cnt_q, req_cnt_d;
    logic [OFFSET_W:0] recv_cnt_q, recv_cnt_d;
    logic [15:0]       base_addr_q, base_addr_d;

    logic              word_accept;
    logic              last_word;

    // A return only counts while filling and while a request is still outstanding.
    assign word_accept = rst_n && (state_q == ST_FILL) && memory_data_valid
                         && (recv_cnt_q != req_cnt_q);
    assign last_word   = word_accept && (recv_cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_cnt_q   <= '0;
            recv_cnt_q  <= '0;
            base_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            req_cnt_q   <= req_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_addr_q <= base_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_cnt_d   = req_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        base_addr_d = base_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (miss_detected) begin
                    base_addr_d = miss_address & BLOCK_MASK;
                    req_cnt_d   = '0;
                    recv_cnt_d  = '0;
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                if (req_cnt_q != CNT_FULL) begin
                    req_cnt_d = req_cnt_q + 1'b1;
                end
                if (word_accept) begin
                    recv_cnt_d = recv_cnt_q + 1'b1;
                end
                if (last_word) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        fsm_busy         = 1'b0;
        mem_req          = 1'b0;
        memory_address   = 16'h0000;
        write_data_array = word_accept;
        write_tag_array  = last_word;
        word_offset      = recv_cnt_q[OFFSET_W-1:0];
        fill_data        = word_accept ? memory_data : 16'h0000;
        fill_done        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                fsm_busy = rst_n && miss_detected;
            end
            ST_FILL: begin
                fsm_busy = rst_n;
                if (req_cnt_q != CNT_FULL) begin
                    mem_req        = 1'b1;
                    memory_address = base_addr_q + 16'({req_cnt_q, 1'b0});
                end
            end
            ST_DONE: begin
                fill_done = 1'b1;
            end
            default: begin
                fsm_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a pipelined memory model (latency 4, optional gaps)
// answers requests; expected requests and array writes are queued when each miss is driven.
module tb_cache_fill_fsm;

    localparam int WORDS = 8;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [2:0]  word_offset;
    logic [15:0] fill_data;
    logic        fill_done;

    always #5 clk = ~clk;

    cache_fill_fsm #(.WORDS(WORDS), .OFFSET_W(3)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_req           (mem_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .word_offset       (word_offset),
        .fill_data         (fill_data),
        .fill_done         (fill_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] exp_addr_q[$];
    logic [18:0] exp_wr_q[$];
    int          ret_t_q[$];
    logic [15:0] ret_d_q[$];

    bit fill_on       = 1'b0;
    bit force_valid   = 1'b0;
    bit rst_chk       = 1'b0;
    int done_cyc      = -1;
    int tag_cyc       = -1;
    int first_req_cyc = -1;
    int last_ret_t    = 0;
    int gap_max       = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A3C ^ {a[7:0], a[15:8]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic start_fill(input logic [15:0] addr);
        logic [15:0] base;
        logic [15:0] a;
        base = addr & 16'hFFF0;
        for (int i = 0; i < WORDS; i++) begin
            a = base + 16'(2 * i);
            exp_addr_q.push_back(a);
            exp_wr_q.push_back({3'(i), mem_word(a)});
        end
        fill_on = 1'b1;
    endtask

    // One clock: present memory return, sample outputs mid-cycle, update model, advance.
    task automatic step();
        logic [18:0] w;
        logic [15:0] a;
        int          t;
        bit          was_fill;
        memory_data_valid = 1'b0;
        memory_data       = 16'($urandom);
        if (ret_t_q.size() > 0 && ret_t_q[0] <= cyc) begin
            void'(ret_t_q.pop_front());
            memory_data       = ret_d_q.pop_front();
            memory_data_valid = 1'b1;
        end else if (force_valid) begin
            memory_data_valid = 1'b1;
        end
        #1;
        was_fill = fill_on;
        if (!rst_n) begin
            if (rst_chk) begin
                check("rst_fsm_busy", fsm_busy, 0);
                check("rst_mem_req", mem_req, 0);
                check("rst_mem_addr", memory_address, 0);
                check("rst_wr_data", write_data_array, 0);
                check("rst_wr_tag", write_tag_array, 0);
                check("rst_word_offset", word_offset, 0);
                check("rst_fill_data", fill_data, 0);
                check("rst_fill_done", fill_done, 0);
            end
            exp_addr_q.delete();
            exp_wr_q.delete();
            fill_on  = 1'b0;
            done_cyc = -1;
        end else begin
            check("fsm_busy", fsm_busy, fill_on || (cyc != done_cyc && miss_detected));
            check("fill_done", fill_done, cyc == done_cyc);
            check("mem_req", mem_req, fill_on && exp_addr_q.size() > 0);
            if (mem_req && exp_addr_q.size() > 0) begin
                a = exp_addr_q.pop_front();
                check("mem_addr", memory_address, a);
                t = cyc + LAT;
                if (t <= last_ret_t) t = last_ret_t + 1;
                if (gap_max > 0) t += $urandom_range(0, gap_max);
                last_ret_t = t;
                ret_t_q.push_back(t);
                ret_d_q.push_back(mem_word(memory_address));
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            check("wr_data_array", write_data_array,
                  fill_on && memory_data_valid && exp_wr_q.size() > 0);
            if (write_data_array && exp_wr_q.size() > 0) begin
                w = exp_wr_q.pop_front();
                check("word_offset", word_offset, w[18:16]);
                check("fill_data", fill_data, w[15:0]);
                check("wr_tag_last", write_tag_array, w[18:16] == 3'(WORDS - 1));
                if (w[18:16] == 3'(WORDS - 1)) begin
                    tag_cyc  = cyc;
                    done_cyc = cyc + 1;
                    fill_on  = 1'b0;
                end
            end else begin
                check("wr_tag_nowrite", write_tag_array, 0);
            end
            if (miss_detected && !was_fill && cyc != done_cyc) start_fill(miss_address);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_fill(input logic [15:0] addr, input int gap, input bit toggle,
                            input bit timing);
        int base;
        gap_max       = gap;
        done_cyc      = -1;
        tag_cyc       = -1;
        first_req_cyc = -1;
        base          = cyc;
        miss_detected = 1'b1;
        miss_address  = addr;
        step();
        miss_detected = 1'b0;
        for (int i = 0; i < 80 && !(done_cyc >= 0 && cyc > done_cyc); i++) begin
            if (toggle) begin
                miss_detected = 1'($urandom);
                miss_address  = 16'($urandom);
            end
            step();
        end
        miss_detected = 1'b0;
        check("fill_completed", (done_cyc >= 0 && cyc > done_cyc), 1);
        check("req_all_issued", exp_addr_q.size(), 0);
        check("wr_all_seen", exp_wr_q.size(), 0);
        if (timing) begin
            check("first_req_cycle", first_req_cyc - base, 1);
            check("tag_cycle", tag_cyc - base, 12);
            check("done_cycle", done_cyc - base, 13);
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        miss_detected     = 1'b1;
        miss_address      = 16'h1236;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0000;
        force_valid       = 1'b1;
        rst_chk           = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        step();
        step();
        rst_n         = 1'b1;
        rst_chk       = 1'b0;
        force_valid   = 1'b0;
        miss_detected = 1'b0;
        step();

        run_fill(16'h1236, 0, 1'b0, 1'b1);
        step();
        run_fill(16'hFFF9, 0, 1'b0, 1'b0);
        step();
        run_fill(16'h4A17, 3, 1'b0, 1'b0);
        step();
        run_fill(16'h8008, 0, 1'b1, 1'b0);
        step();
        step();

        force_valid = 1'b1;
        repeat (3) step();
        force_valid = 1'b0;
        step();

        gap_max       = 0;
        done_cyc      = -1;
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        step();
        miss_detected = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        step();
        rst_n       = 1'b1;
        force_valid = 1'b1;
        repeat (5) step();
        force_valid = 1'b0;
        ret_t_q.delete();
        ret_d_q.delete();
        repeat (2) step();

        run_fill(16'h2C40, 0, 1'b0, 1'b1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
